timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
// Programmable down-counting timer on the CPU-side bridge; its irq output drives
// CP0 hwInt[0]. Software configures it via sw/lw to three word registers.
// One-shot or auto-reload; irq gated by an interrupt-mask bit. CP0 does the
// IM/IE/EXL gating; this block only raises the line.
// PARAMETERS
// CNT_W  32  width of PRESET/COUNT; zero-extended to 32 bits on read, upper write bits dropped
// PORTS
// clk    in   1   system clock, all state updates on posedge
// reset  in   1   synchronous, active-high
// addr   in   2   word select: 0=CTRL, 1=PRESET, 2=COUNT(read-only), 3=reserved
// we     in   1   write strobe, sampled at posedge
// wdata  in   32  write data
// rdata  out  32  combinational read of addressed register; addr 3 reads 0
// irq    out  1   interrupt request to CP0 hwInt[0]; irq = pending & CTRL.IM
// BEHAVIOUR
// - Reset: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE; irq=0, rdata=0.
// - CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x = one-shot),
//   [3] IM; [31:4] read 0, writes ignored. Writes to COUNT/addr 3 ignored.
// - Any write to CTRL or PRESET clears pending (software acknowledge).
// - FSM, one transition per posedge:
//   IDLE: EN=1 -> LOAD; else stay, COUNT held.
//   LOAD: COUNT<=PRESET -> CNT (EN=0 here -> IDLE, COUNT unchanged).
//   CNT : EN=0 -> IDLE, COUNT frozen; COUNT>1 -> COUNT-1, stay;
//         COUNT<=1 -> COUNT<=0, pending<=1 -> INT.
//   INT : one-shot: CTRL.EN<=0 -> IDLE, pending held until acknowledged.
//         auto-reload: pending<=0 -> LOAD if EN=1, else IDLE.
// - Latency: CTRL write (EN=1) at edge N with PRESET=P>=1 -> LOAD after N+1,
//   COUNT=P after N+2, COUNT=0 and pending=1 after N+2+P. PRESET=0 behaves as 1.
// - Auto-reload: irq high exactly one cycle per period, period = P+2 cycles.
// - Simultaneous events: a CTRL write wins over the FSM's INT-state EN clear;
//   the written EN value is used next cycle. The FSM setting pending wins over a
//   same-edge acknowledge. A PRESET write during CNT takes effect only at the next
//   LOAD. A CTRL write with EN=0 during CNT freezes COUNT; re-enabling reloads via LOAD.
// - IM=0 masks irq but pending still sets; setting IM later raises irq at once.
// - Reset mid-count returns everything to reset values on that edge; no irq.
// - COUNT never wraps: decrement only when COUNT>1, so 0 is the floor.
// TESTING
// - Reset, read all addrs -> rdata=0 for addr 0..3, irq=0.
// - PRESET=5, CTRL=0x9 (EN,IM, one-shot) at edge N -> COUNT 5,4,3,2,1,0;
//   irq rises after N+7 and stays high; CTRL.EN reads 0; write CTRL=0x8 -> irq=0.
// - PRESET=3, CTRL=0xB (auto-reload) -> irq 1-cycle pulses every 5 cycles, 4 pulses checked.
// - PRESET=10 one-shot, CTRL=0x1 (IM=0) -> COUNT hits 0, irq=0; write CTRL=0x8 (IM set,
//   ack) -> irq stays 0 since pending cleared.
// - Mid-count (COUNT=4) write CTRL=0x8 -> COUNT frozen at 4; write CTRL=0x9 -> reload
//   to PRESET; PRESET write during CNT does not alter current COUNT.
// - Reset asserted while COUNT=2, auto-reload -> next cycle state IDLE, COUNT=0,
//   CTRL=0, irq=0; PRESET=0 run -> pending after N+3.

Source files
------------

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter
//  Brief    : Programmable down-counting timer with one-shot / auto-reload
//             modes and a maskable interrupt line for CP0 hwInt[0].
//             Register map (word select on addr):
//               0 = CTRL   [0] EN, [2:1] MODE, [3] IM
//               1 = PRESET reload value
//               2 = COUNT  current value, read-only
//               3 = reserved, reads 0
//  Revision : 1.0  initial release
// ============================================================================
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0]       c_addr_ctrl   = 2'd0;
  localparam logic [1:0]       c_addr_preset = 2'd1;
  localparam logic [1:0]       c_addr_count  = 2'd2;
  localparam logic [1:0]       c_mode_auto   = 2'b01;
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_pending;

  logic [CNT_W-1:0] w_count_nxt;
  logic             w_set_pend;
  logic             w_clr_pend_fsm;
  logic             w_clr_en;
  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic             w_auto;
  logic [31:0]      w_preset_ext;
  logic [31:0]      w_count_ext;

  assign w_wr_ctrl   = we && (addr == c_addr_ctrl);
  assign w_wr_preset = we && (addr == c_addr_preset);
  // MODE 1x falls back to one-shot, so only 01 means auto-reload.
  assign w_auto      = (r_mode == c_mode_auto);

  // Zero-extend the counter-width registers onto the 32-bit read bus.
  generate
    if (CNT_W < 32) begin : g_ext_pad
      assign w_preset_ext = {{(32-CNT_W){1'b0}}, r_preset};
      assign w_count_ext  = {{(32-CNT_W){1'b0}}, r_count};
    end else begin : g_ext_full
      assign w_preset_ext = r_preset;
      assign w_count_ext  = r_count;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; EN is the registered value, so a CTRL
  // write only influences the FSM from the following cycle on.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_set_pend     = 1'b0;
    w_clr_pend_fsm = 1'b0;
    w_clr_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_en) begin
          w_count_nxt = r_preset;
          w_state_nxt = S_CNT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > c_one) begin
          w_count_nxt = r_count - c_one;
        end else begin
          // Covers COUNT of 1 and of 0, so PRESET=0 behaves like 1.
          w_count_nxt = '0;
          w_set_pend  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_clr_pend_fsm = 1'b1;
          w_state_nxt    = r_en ? S_LOAD : S_IDLE;
        end else begin
          w_clr_en    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Software-visible registers; a CTRL write beats the FSM's EN clear and the
  // FSM's pending set beats a same-edge acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_mode    <= 2'b00;
      r_im      <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= wdata[0];
        r_mode <= wdata[2:1];
        r_im   <= wdata[3];
      end else if (w_clr_en) begin
        r_en <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= wdata[CNT_W-1:0];
      end

      r_count <= w_count_nxt;

      if (w_set_pend) begin
        r_pending <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset || w_clr_pend_fsm) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Combinational register read-back.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      c_addr_ctrl:   rdata = {28'd0, r_im, r_mode, r_en};
      c_addr_preset: rdata = w_preset_ext;
      c_addr_count:  rdata = w_count_ext;
      default:       rdata = 32'd0;
    endcase
  end

  assign irq = r_pending & r_im;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_counter
//  Brief    : Self-checking bench for timer_counter using a table of directed
//             one-cycle vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int errors;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[13];

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive on the falling edge, then select the read address just
  // after the rising edge so the combinational read is sampled mid-cycle.
  task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [1:0] ra);
    @(negedge clk);
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    addr = ra;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_rd, input logic exp_irq);
    checks++;
    if (rdata !== exp_rd || irq !== exp_irq) begin
      errors++;
      $display("FAIL %s: got rdata=%08h irq=%b, expected rdata=%08h irq=%b",
               name, rdata, irq, exp_rd, exp_irq);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check(name, 32'd0, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = 2'd0;
    wdata  = 32'd0;

    // One-shot, PRESET=5, CTRL=0x9 written at edge N (vector 1).
    vecs[0]  = '{1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 32'h9, 2'd0, 32'h9, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd5, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd4, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 32'h8, 2'd0, 32'h8, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};

    // Reset values on every address.
    do_reset();
    check_all_zero("reset_read");

    // Table-driven one-shot run.
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].raddr);
      check($sformatf("oneshot_v%0d", i), vecs[i].exp_rdata, vecs[i].exp_irq);
    end

    // Auto-reload PRESET=3: one-cycle irq pulse every 5 cycles.
    do_reset();
    cycle(1'b1, 2'd1, 32'd3, 2'd1);
    check("ar_preset", 32'd3, 1'b0);
    cycle(1'b1, 2'd0, 32'hB, 2'd0);
    check("ar_ctrl", 32'hB, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      cycle(1'b0, 2'd0, 32'd0, 2'd0);
      check($sformatf("ar_k%0d", k), 32'hB, (k >= 5) && (k % 5 == 0));
    end

    // IM=0: pending sets silently; CTRL write acks it so irq stays low.
    do_reset();
    cycle(1'b1, 2'd1, 32'd10, 2'd1);
    check("m_preset", 32'd10, 1'b0);
    cycle(1'b1, 2'd0, 32'h1, 2'd2);
    check("m_ctrl", 32'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 2'd0, 32'd0, 2'd2);
      check($sformatf("m_k%0d", k), (k < 2) ? 32'd0 : 32'(12 - k), 1'b0);
    end
    cycle(1'b0, 2'd0, 32'd0, 2'd0);
    check("m_en_clr", 32'h0, 1'b0);
    cycle(1'b1, 2'd0, 32'h8, 2'd0);
    check("m_ack", 32'h8, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd0);
    check("m_after_ack", 32'h8, 1'b0);

    // Same-edge priorities: pending set beats ack, CTRL write beats EN clear.
    do_reset();
    cycle(1'b1, 2'd1, 32'd2, 2'd1);
    check("p_preset", 32'd2, 1'b0);
    cycle(1'b1, 2'd0, 32'h1, 2'd2);
    check("p_n0", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("p_n1", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("p_n2", 32'd2, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("p_n3", 32'd1, 1'b0);
    cycle(1'b1, 2'd0, 32'h9, 2'd0);
    check("p_set_wins", 32'h9, 1'b1);
    cycle(1'b1, 2'd0, 32'h9, 2'd0);
    check("p_wr_wins", 32'h9, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("p_load", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("p_reload", 32'd2, 1'b0);

    // Freeze mid-count, PRESET write during CNT only applies at next LOAD.
    do_reset();
    cycle(1'b1, 2'd1, 32'd7, 2'd1);
    check("f_preset", 32'd7, 1'b0);
    cycle(1'b1, 2'd0, 32'h9, 2'd2);
    check("f_n0", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_n1", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_n2", 32'd7, 1'b0);
    cycle(1'b1, 2'd1, 32'd9, 2'd2);
    check("f_preset_wr", 32'd6, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_n4", 32'd5, 1'b0);
    cycle(1'b1, 2'd0, 32'h8, 2'd2);
    check("f_stop", 32'd4, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_frozen1", 32'd4, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_frozen2", 32'd4, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd1);
    check("f_new_preset", 32'd9, 1'b0);
    cycle(1'b1, 2'd0, 32'h9, 2'd2);
    check("f_reen", 32'd4, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_load", 32'd4, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("f_reload", 32'd9, 1'b0);

    // Reset mid-count in auto-reload, then a PRESET=0 run.
    do_reset();
    cycle(1'b1, 2'd1, 32'd3, 2'd1);
    check("r_preset", 32'd3, 1'b0);
    cycle(1'b1, 2'd0, 32'hB, 2'd2);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("r_cnt3", 32'd3, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("r_cnt2", 32'd2, 1'b0);
    do_reset();
    check_all_zero("r_midreset");
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("r_idle", 32'd0, 1'b0);
    cycle(1'b1, 2'd0, 32'h9, 2'd2);
    check("z_n0", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("z_n1", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("z_n2", 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 32'd0, 2'd2);
    check("z_n3", 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
